gpio_in_reader: RTL and testbench
=================================

GPIO_IN_READER -- requirements
Module: gpio_in_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of input pins (1..32).
REQ-002 SHALL have parameter DEB_CYCLES, default 500000, consecutive stable cycles required to accept a level change (10 ms at 50 MHz).
REQ-003 SHALL have parameter CNT_W, default 20, debounce counter width; DEB_CYCLES SHALL be less than or equal to 2^CNT_W.
REQ-004 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port gpio_i, input, WIDTH, asynchronous switch/button pins.
REQ-007 SHALL have port rd_en, input, 1, one-cycle read strobe from the MIPS data path.
REQ-008 SHALL have port addr, input, 2, register select.
REQ-009 SHALL have port rd_data, output, 32, read data.
REQ-010 SHALL have port rd_valid, output, 1, qualifies rd_data.
REQ-011 SHALL have port irq, output, 1, level interrupt; present only under GPIO_IN_IRQ_EN.

Function
REQ-012 Each gpio_i bit SHALL pass through a two-flop synchronizer before any other use.
REQ-013 Each bit SHALL have its own debounce counter: while synced bit differs from stable bit, counter increments each cycle; when synced bit equals stable bit, counter clears to 0.
REQ-014 When a counter reaches DEB_CYCLES-1 while the bit still differs, the stable bit SHALL take the synced value on that edge and the counter SHALL clear.
REQ-015 Pin-to-stable latency SHALL be exactly 2 + DEB_CYCLES cycles for a clean step; any glitch shorter than DEB_CYCLES cycles SHALL NOT change the stable bit.
REQ-016 A stable 0->1 transition SHALL set the matching bit of sticky register RISE; a stable 1->0 transition SHALL set the matching bit of FALL.
REQ-017 Register map: addr 0 = DATA (stable levels), 1 = RISE, 2 = FALL, 3 = CONFIG {16'd0, 8'd0, 8'dWIDTH}; unused upper bits read 0.
REQ-018 A read SHALL have 1-cycle latency: rd_valid high exactly one cycle after rd_en, with rd_data holding the selected register as sampled on the rd_en edge; otherwise rd_valid 0 and rd_data 0.
REQ-019 A read of RISE or FALL SHALL clear that register on the rd_en edge (read-to-clear); other addresses SHALL have no side effect.
REQ-020 If a new event for a bit occurs on the same edge as its clearing read, the bit SHALL remain set after the edge and the read SHALL return the pre-edge value.
REQ-021 Back-to-back reads on consecutive cycles SHALL each be served; no stall exists.

Reset
REQ-022 On reset high at a clock edge: synchronizers, stable bits, counters, RISE, FALL, rd_data, rd_valid (and irq) SHALL become 0.
REQ-023 Reset asserted mid-debounce or mid-read SHALL discard the pending count and pending read; no event SHALL be generated by the reset itself.
REQ-024 After reset release, a pin held high SHALL produce a RISE event after 2 + DEB_CYCLES cycles.

Configuration
REQ-025 With macro GPIO_IN_IRQ_EN defined, irq SHALL equal the registered OR of all RISE and FALL bits, updating one cycle after the registers change.
REQ-026 Without GPIO_IN_IRQ_EN, port irq and its logic SHALL be absent; all other behaviour identical.

Verification (bench uses WIDTH=8, DEB_CYCLES=4)
REQ-027 Reset, then gpio_i=8'h01 held -> DATA reads 32'h1 no earlier than cycle 6 after the change; RISE reads 32'h1, then reads 0 on second read.
REQ-028 gpio_i bit 3 pulsed high for 3 cycles -> DATA and RISE stay 0.
REQ-029 gpio_i 8'hFF -> 8'h00 after settling -> FALL reads 32'hFF; DATA reads 0.
REQ-030 RISE read issued on same edge a new bit-0 rise is accepted -> returns 0, following read returns 32'h1.
REQ-031 reset pulsed 2 cycles into a 4-cycle debounce of bit 5 -> no event, DATA 0; debounce restarts from 0.
REQ-032 With GPIO_IN_IRQ_EN, bit-7 rise -> irq 1 one cycle after RISE sets; irq 0 one cycle after RISE read clears it.

Source files
------------

// File: rtl/gpio_in_if.sv
// Read-port bundle between the MIPS data path (master) and gpio_in_reader (slave).
// Handshake: rd_en is a one-cycle strobe; rd_valid is high exactly one cycle later with rd_data; no stall.
interface gpio_in_if;
  logic        rd_en;
  logic [1:0]  addr;
  logic [31:0] rd_data;
  logic        rd_valid;

  modport master (output rd_en, output addr, input rd_data, input rd_valid);
  modport slave  (input rd_en, input addr, output rd_data, output rd_valid);
endinterface

// File: rtl/gpio_in_reader.sv
// Debounced GPIO input block: per-pin 2-flop sync, debounce counter, sticky RISE/FALL, read port.
// Optional level interrupt output irq is built only when macro GPIO_IN_IRQ_EN is defined.
module gpio_in_reader #(
  parameter int WIDTH      = 8,
  parameter int DEB_CYCLES = 500000,
  parameter int CNT_W      = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] gpio_i,
  gpio_in_if.slave         bus
`ifdef GPIO_IN_IRQ_EN
  ,
  output logic             irq
`endif
);

  logic [WIDTH-1:0] sync1, sync2, stable;
  logic [WIDTH-1:0] rise, fall;
  logic [WIDTH-1:0] accept, rise_evt, fall_evt;
  logic [WIDTH-1:0] clr_rise, clr_fall;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [31:0]      sel_data;

  // A bit is accepted on the edge its counter sits at DEB_CYCLES-1 and it still differs.
  always_comb begin
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      accept[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_W'(DEB_CYCLES - 1));
    end
    rise_evt = accept & sync2;
    fall_evt = accept & ~sync2;
    clr_rise = {WIDTH{bus.rd_en && (bus.addr == 2'd1)}};
    clr_fall = {WIDTH{bus.rd_en && (bus.addr == 2'd2)}};
  end

  always_comb begin
    sel_data = '0;
    case (bus.addr)
      2'd0:    sel_data[WIDTH-1:0] = stable;
      2'd1:    sel_data[WIDTH-1:0] = rise;
      2'd2:    sel_data[WIDTH-1:0] = fall;
      default: sel_data[7:0]       = 8'(WIDTH);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1        <= '0;
      sync2        <= '0;
      stable       <= '0;
      rise         <= '0;
      fall         <= '0;
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1  <= gpio_i;
      sync2  <= sync1;
      stable <= stable ^ accept;
      for (int i = 0; i < WIDTH; i++) begin
        if ((sync2[i] == stable[i]) || accept[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
      // A new event wins over the clearing read on the same edge; the read still sees the old value.
      rise         <= (rise & ~clr_rise) | rise_evt;
      fall         <= (fall & ~clr_fall) | fall_evt;
      bus.rd_valid <= bus.rd_en;
      bus.rd_data  <= bus.rd_en ? sel_data : 32'd0;
    end
  end

`ifdef GPIO_IN_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= |{rise, fall};
    end
  end
`endif

endmodule

// File: tb/tb_gpio_in_reader.sv
// Scoreboard bench for gpio_in_reader (WIDTH=8, DEB_CYCLES=4) with a window-based reference model.
// Define GPIO_IN_IRQ_EN for both files to also check the irq output.
module tb_gpio_in_reader;
  localparam int W   = 8;
  localparam int DEB = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] gpio_i = '0;
  logic         irq;

  gpio_in_if bus ();

  gpio_in_reader #(.WIDTH(W), .DEB_CYCLES(DEB), .CNT_W(20)) dut (
    .clk    (clk),
    .reset  (reset),
    .gpio_i (gpio_i),
    .bus    (bus)
`ifdef GPIO_IN_IRQ_EN
    ,
    .irq    (irq)
`endif
  );

`ifndef GPIO_IN_IRQ_EN
  assign irq = 1'b0;
`endif

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // A pin value is accepted once the synchronized samples (pins delayed two edges) of the last
  // DEB edges all differ from the current stable value.
  logic [W-1:0]  m_data = '0, m_rise = '0, m_fall = '0;
  logic [W-1:0]  hist[$];
  logic [31:0]   exp_q[$];
  logic          pend_vld = 1'b0, pend_irq = 1'b0;
  logic          obs_vld = 1'b0, obs_irq = 1'b0;
  logic          armed = 1'b0;
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic tick();
    logic [W-1:0] diff;
    logic [31:0]  sel;
    if (reset) begin
      m_data = '0; m_rise = '0; m_fall = '0;
      hist.delete();
      for (int k = 0; k < DEB + 2; k++) hist.push_back('0);
      pend_vld = 1'b0;
      pend_irq = 1'b0;
    end else begin
      pend_irq = |{m_rise, m_fall};
      pend_vld = bus.rd_en;
      if (bus.rd_en) begin
        case (bus.addr)
          2'd0:    sel = {24'd0, m_data};
          2'd1:    sel = {24'd0, m_rise};
          2'd2:    sel = {24'd0, m_fall};
          default: sel = 32'd8;
        endcase
        exp_q.push_back(sel);
      end
      hist.push_front(gpio_i);
      void'(hist.pop_back());
      diff = '1;
      for (int k = 2; k <= DEB + 1; k++) diff &= hist[k] ^ m_data;
      if (bus.rd_en && bus.addr == 2'd1) m_rise = '0;
      if (bus.rd_en && bus.addr == 2'd2) m_fall = '0;
      m_rise |= diff & ~m_data;
      m_fall |= diff & m_data;
      m_data ^= diff;
    end
    @(posedge clk);
    obs_vld = pend_vld;
    obs_irq = pend_irq;
    #1;
  endtask

  // ---------------- driver ----------------
  task automatic cyc(input logic [W-1:0] g, input logic rd, input logic [1:0] a);
    gpio_i     = g;
    bus.rd_en  = rd;
    bus.addr   = a;
    tick();
  endtask

  task automatic idle(input logic [W-1:0] g, input int n);
    for (int i = 0; i < n; i++) cyc(g, 1'b0, 2'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (armed) begin
      n_cmp++;
      if (bus.rd_valid !== obs_vld) begin
        n_bad++;
        $display("FAIL rd_valid: got %b want %b at %0t", bus.rd_valid, obs_vld, $time);
      end
      if (bus.rd_valid === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL rd_data_unexpected: got %h want none at %0t", bus.rd_data, $time);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (bus.rd_data !== e) begin
            n_bad++;
            $display("FAIL rd_data: got %h want %h at %0t", bus.rd_data, e, $time);
          end
        end
      end else if (obs_vld == 1'b0) begin
        n_cmp++;
        if (bus.rd_data !== 32'd0) begin
          n_bad++;
          $display("FAIL rd_data_idle: got %h want 00000000 at %0t", bus.rd_data, $time);
        end
      end
`ifdef GPIO_IN_IRQ_EN
      n_cmp++;
      if (irq !== obs_irq) begin
        n_bad++;
        $display("FAIL irq: got %b want %b at %0t", irq, obs_irq, $time);
      end
`endif
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] g;
    bus.rd_en = 1'b0;
    bus.addr  = 2'd0;

    // Reset and reset-state reads of all four registers
    reset = 1'b1;
    tick();
    tick();
    armed = 1'b1;
    reset = 1'b0;
    for (int a = 0; a < 4; a++) cyc('0, 1'b1, 2'(a));

    // Clean step on bit 0, DATA polled every cycle, then RISE read twice
    for (int i = 0; i < 9; i++) cyc(8'h01, 1'b1, 2'd0);
    cyc(8'h01, 1'b1, 2'd1);
    cyc(8'h01, 1'b1, 2'd1);

    // Back to 0, then a 3-cycle glitch on bit 3
    idle(8'h00, 8);
    cyc(8'h00, 1'b1, 2'd1);
    cyc(8'h00, 1'b1, 2'd2);
    for (int i = 0; i < 3; i++) cyc(8'h08, 1'b1, 2'd0);
    for (int i = 0; i < 8; i++) cyc(8'h00, 1'b1, 2'd0);
    cyc(8'h00, 1'b1, 2'd1);

    // All high, settle, all low: FALL = FF, DATA = 0
    idle(8'hFF, 8);
    cyc(8'hFF, 1'b1, 2'd1);
    idle(8'h00, 8);
    cyc(8'h00, 1'b1, 2'd2);
    cyc(8'h00, 1'b1, 2'd0);
    cyc(8'h00, 1'b1, 2'd2);

    // RISE read on the same edge a bit-0 rise is accepted (6th edge after the change)
    for (int i = 0; i < 5; i++) cyc(8'h01, 1'b0, 2'd0);
    cyc(8'h01, 1'b1, 2'd1);
    cyc(8'h01, 1'b1, 2'd1);
    cyc(8'h01, 1'b1, 2'd1);
    idle(8'h00, 8);
    cyc(8'h00, 1'b1, 2'd2);

    // Reset two cycles into a bit-5 debounce, pin held high afterwards
    cyc(8'h20, 1'b0, 2'd0);
    cyc(8'h20, 1'b1, 2'd0);
    reset = 1'b1;
    cyc(8'h20, 1'b0, 2'd0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) cyc(8'h20, 1'b1, 2'd0);
    cyc(8'h20, 1'b1, 2'd1);
    cyc(8'h20, 1'b1, 2'd2);

    // Bit-7 rise then RISE read (irq set and cleared)
    idle(8'ha0, 9);
    cyc(8'ha0, 1'b1, 2'd1);
    idle(8'ha0, 3);

    // Randomized phase: variable hold times give both glitches and accepted changes
    g = 8'ha0;
    for (int blk = 0; blk < 120; blk++) begin
      int hold;
      g    = (($urandom_range(0, 1) == 1) ? 8'($urandom()) : (g ^ (8'h1 << $urandom_range(0, 7))));
      hold = $urandom_range(1, 7);
      for (int i = 0; i < hold; i++) begin
        reset = ($urandom_range(0, 199) == 0);
        cyc(g, ($urandom_range(0, 9) < 4), 2'($urandom_range(0, 3)));
      end
      reset = 1'b0;
    end
    for (int a = 0; a < 4; a++) cyc(g, 1'b1, 2'(a));
    idle(g, 3);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending reads want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
